// File: rtl/vx_commit_arb.sv
// Writeback arbiter: merges NUM_REQS commit streams into one registered writeback
// stream with round-robin fairness and per-instruction grant locking.
module vx_commit_arb #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int UUID_W      = 44,
    parameter int DATA_W      = 32,
    parameter int PERF_W      = 44
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_REQS-1:0]                              cmt_valid_i,
    output logic [NUM_REQS-1:0]                              cmt_ready_o,
    input  logic [NUM_REQS-1:0][UUID_W-1:0]                  cmt_uuid_i,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]                 cmt_wid_i,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]             cmt_tmask_i,
    input  logic [NUM_REQS-1:0][31:0]                        cmt_PC_i,
    input  logic [NUM_REQS-1:0]                              cmt_wb_i,
    input  logic [NUM_REQS-1:0][4:0]                         cmt_rd_i,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][DATA_W-1:0] cmt_data_i,
    input  logic [NUM_REQS-1:0]                              cmt_eop_i,
    output logic                                             wb_valid_o,
    output logic [UUID_W-1:0]                                wb_uuid_o,
    output logic [NW_BITS-1:0]                               wb_wid_o,
    output logic [NUM_THREADS-1:0]                           wb_tmask_o,
    output logic [31:0]                                      wb_PC_o,
    output logic [4:0]                                       wb_rd_o,
    output logic [NUM_THREADS-1:0][DATA_W-1:0]               wb_data_o,
    output logic                                             wb_eop_o,
    output logic [PERF_W-1:0]                                perf_wb_beats_o
);
    localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0] elig, bypass, grant;
    logic [PTR_W-1:0]    ptr_q, ptr_d, owner_q, owner_d, win_idx;
    logic                lock_q, lock_d;
    logic                any_grant, win_eop;

    logic                                   wb_valid_q;
    logic [UUID_W-1:0]                      wb_uuid_q;
    logic [NW_BITS-1:0]                     wb_wid_q;
    logic [NUM_THREADS-1:0]                 wb_tmask_q;
    logic [31:0]                            wb_PC_q;
    logic [4:0]                             wb_rd_q;
    logic [NUM_THREADS-1:0][DATA_W-1:0]     wb_data_q;
    logic                                   wb_eop_q;
    logic [PERF_W-1:0]                      perf_q;

    assign elig   = cmt_valid_i & cmt_wb_i;
    assign bypass = cmt_valid_i & ~cmt_wb_i;

    // Scan from the far end back toward ptr so the last hit is the first in rr order.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        win_idx = '0;
        if (!reset) begin
            if (lock_q) begin
                if (elig[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    win_idx        = owner_q;
                end
            end else begin
                for (int k = NUM_REQS - 1; k >= 0; k--) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= NUM_REQS) idx = idx - NUM_REQS;
                    if (elig[idx]) begin
                        grant      = '0;
                        grant[idx] = 1'b1;
                        win_idx    = PTR_W'(idx);
                    end
                end
            end
        end
    end

    assign any_grant   = |grant;
    assign win_eop     = cmt_eop_i[win_idx];
    assign cmt_ready_o = grant | (bypass & {NUM_REQS{~reset}});

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (any_grant) begin
            if (!win_eop) begin
                lock_d  = 1'b1;
                owner_d = win_idx;
            end else begin
                lock_d = 1'b0;
                ptr_d  = (win_idx == PTR_W'(NUM_REQS - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_uuid_q  <= '0;
            wb_wid_q   <= '0;
            wb_tmask_q <= '0;
            wb_PC_q    <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_eop_q   <= 1'b0;
            perf_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            wb_valid_q <= any_grant;
            if (any_grant) begin
                wb_uuid_q  <= cmt_uuid_i[win_idx];
                wb_wid_q   <= cmt_wid_i[win_idx];
                wb_tmask_q <= cmt_tmask_i[win_idx];
                wb_PC_q    <= cmt_PC_i[win_idx];
                wb_rd_q    <= cmt_rd_i[win_idx];
                wb_data_q  <= cmt_data_i[win_idx];
                wb_eop_q   <= win_eop;
                perf_q     <= perf_q + PERF_W'(1);
            end
        end
    end

    assign wb_valid_o      = wb_valid_q;
    assign wb_uuid_o       = wb_uuid_q;
    assign wb_wid_o        = wb_wid_q;
    assign wb_tmask_o      = wb_tmask_q;
    assign wb_PC_o         = wb_PC_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;
    assign wb_eop_o        = wb_eop_q;
    assign perf_wb_beats_o = perf_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_lock_owner:   assert property (@(posedge clk) disable iff (reset)
                        lock_q |-> ((grant & ~(NUM_REQS'(1) << owner_q)) == '0));

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: reset, rr order, locking, idle owner, bypass, reset-in-lock.
module tb_vx_commit_arb;
    localparam int NR = 5, NT = 4, NWB = 2, UW = 44, DW = 32, PW = 44;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NR-1:0]                 cmt_valid, cmt_ready, cmt_wb, cmt_eop;
    logic [NR-1:0][UW-1:0]         cmt_uuid;
    logic [NR-1:0][NWB-1:0]        cmt_wid;
    logic [NR-1:0][NT-1:0]         cmt_tmask;
    logic [NR-1:0][31:0]           cmt_PC;
    logic [NR-1:0][4:0]            cmt_rd;
    logic [NR-1:0][NT-1:0][DW-1:0] cmt_data;
    logic                          wb_valid, wb_eop;
    logic [UW-1:0]                 wb_uuid;
    logic [NWB-1:0]                wb_wid;
    logic [NT-1:0]                 wb_tmask;
    logic [31:0]                   wb_PC;
    logic [4:0]                    wb_rd;
    logic [NT-1:0][DW-1:0]         wb_data;
    logic [PW-1:0]                 perf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_commit_arb #(.NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB), .UUID_W(UW),
                    .DATA_W(DW), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .cmt_valid_i(cmt_valid), .cmt_ready_o(cmt_ready), .cmt_uuid_i(cmt_uuid),
        .cmt_wid_i(cmt_wid), .cmt_tmask_i(cmt_tmask), .cmt_PC_i(cmt_PC), .cmt_wb_i(cmt_wb),
        .cmt_rd_i(cmt_rd), .cmt_data_i(cmt_data), .cmt_eop_i(cmt_eop),
        .wb_valid_o(wb_valid), .wb_uuid_o(wb_uuid), .wb_wid_o(wb_wid), .wb_tmask_o(wb_tmask),
        .wb_PC_o(wb_PC), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_eop_o(wb_eop),
        .perf_wb_beats_o(perf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmt_valid = '0; cmt_wb = '0; cmt_eop = '0; cmt_uuid = '0; cmt_wid = '0;
        cmt_tmask = '0; cmt_PC = '0; cmt_rd = '0; cmt_data = '0;
    endtask

    task automatic set_req(input int i, input logic [UW-1:0] uuid, input logic [4:0] rd,
                           input logic eop, input logic wb);
        cmt_valid[i] = 1'b1;
        cmt_wb[i]    = wb;
        cmt_eop[i]   = eop;
        cmt_uuid[i]  = uuid;
        cmt_rd[i]    = rd;
        cmt_wid[i]   = NWB'(i);
        cmt_tmask[i] = 4'b1011;
        cmt_PC[i]    = 32'h8000_0000 + 32'(i * 4);
        for (int l = 0; l < NT; l++) cmt_data[i][l] = {uuid[15:0], 16'(l)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %0h exp 0", wb_valid); end
        n_checks++; if (wb_uuid !== '0 || wb_rd !== '0 || wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_fields got uuid=%0h rd=%0h", wb_uuid, wb_rd); end
        n_checks++; if (perf !== '0) begin n_fail++; $display("FAIL reset_perf got %0d exp 0", perf); end
        n_checks++; if (cmt_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b exp 00000", cmt_ready); end
    endtask

    task automatic test_single();
        do_reset();
        tick(); tick();
        set_req(0, 44'd7, 5'd3, 1'b1, 1'b1);
        #1;
        n_checks++; if (cmt_ready !== 5'b00001) begin n_fail++; $display("FAIL single_ready got %b exp 00001", cmt_ready); end
        tick();
        clear_inputs();
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid got %0h exp 1", wb_valid); end
        n_checks++; if (wb_uuid !== 44'd7 || wb_rd !== 5'd3) begin n_fail++; $display("FAIL single_fields got uuid=%0d rd=%0d exp 7 3", wb_uuid, wb_rd); end
        n_checks++; if (wb_PC !== 32'h8000_0000 || wb_tmask !== 4'b1011 || wb_eop !== 1'b1 || wb_wid !== 2'd0) begin n_fail++; $display("FAIL single_meta got pc=%0h tm=%b eop=%0h", wb_PC, wb_tmask, wb_eop); end
        n_checks++; if (wb_data[2] !== {16'd7, 16'd2}) begin n_fail++; $display("FAIL single_data got %0h exp 00070002", wb_data[2]); end
        n_checks++; if (perf !== 44'd1) begin n_fail++; $display("FAIL single_perf got %0d exp 1", perf); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %0h exp 0", wb_valid); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 44'(100 + i), 5'(i + 1), 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            exp_rdy = 5'b00001 << (c % NR);
            #1;
            n_checks++; if (cmt_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready c=%0d got %b exp %b", c, cmt_ready, exp_rdy); end
            tick();
            n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== 44'(100 + c % NR)) begin n_fail++; $display("FAIL rr_wb c=%0d got v=%0h uuid=%0d exp 1 %0d", c, wb_valid, wb_uuid, 100 + c % NR); end
        end
        n_checks++; if (perf !== 44'd10) begin n_fail++; $display("FAIL rr_perf got %0d exp 10", perf); end
        clear_inputs();
    endtask

    task automatic test_lock_multibeat();
        logic [NR-1:0] exp_rdy [4] = '{5'b00010, 5'b00010, 5'b00010, 5'b00001};
        logic [UW-1:0] exp_uid [4] = '{44'd21, 44'd22, 44'd23, 44'd10};
        do_reset();
        set_req(0, 44'd10, 5'd1, 1'b1, 1'b1);
        tick();
        n_checks++; if (wb_uuid !== 44'd10) begin n_fail++; $display("FAIL mb_pre got %0d exp 10", wb_uuid); end
        for (int b = 0; b < 4; b++) begin
            if (b < 3) set_req(1, 44'(21 + b), 5'd9, (b == 2), 1'b1);
            else begin cmt_valid[1] = 1'b0; cmt_wb[1] = 1'b0; end
            #1;
            n_checks++; if (cmt_ready !== exp_rdy[b]) begin n_fail++; $display("FAIL mb_ready b=%0d got %b exp %b", b, cmt_ready, exp_rdy[b]); end
            tick();
            n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== exp_uid[b]) begin n_fail++; $display("FAIL mb_wb b=%0d got v=%0h uuid=%0d exp %0d", b, wb_valid, wb_uuid, exp_uid[b]); end
        end
        clear_inputs();
    endtask

    task automatic test_idle_owner();
        do_reset();
        set_req(1, 44'd31, 5'd4, 1'b0, 1'b1);
        set_req(2, 44'd40, 5'd5, 1'b1, 1'b1);
        #1;
        n_checks++; if (cmt_ready !== 5'b00010) begin n_fail++; $display("FAIL idle_first got %b exp 00010", cmt_ready); end
        tick();
        cmt_valid[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (cmt_ready !== 5'b00000) begin n_fail++; $display("FAIL idle_ready c=%0d got %b exp 00000", c, cmt_ready); end
            tick();
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_wb c=%0d got %0h exp 0", c, wb_valid); end
        end
        set_req(1, 44'd32, 5'd4, 1'b1, 1'b1);
        #1;
        n_checks++; if (cmt_ready !== 5'b00010) begin n_fail++; $display("FAIL idle_eop got %b exp 00010", cmt_ready); end
        tick();
        cmt_valid[1] = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== 44'd32) begin n_fail++; $display("FAIL idle_eop_wb got uuid=%0d exp 32", wb_uuid); end
        #1;
        n_checks++; if (cmt_ready !== 5'b00100) begin n_fail++; $display("FAIL idle_csr got %b exp 00100", cmt_ready); end
        tick();
        clear_inputs();
        n_checks++; if (wb_uuid !== 44'd40 || perf !== 44'd3) begin n_fail++; $display("FAIL idle_csr_wb got uuid=%0d perf=%0d exp 40 3", wb_uuid, perf); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_req(3, 44'd60, 5'd6, 1'b1, 1'b0);
        set_req(4, 44'd50, 5'd7, 1'b1, 1'b1);
        #1;
        n_checks++; if (cmt_ready !== 5'b11000) begin n_fail++; $display("FAIL byp_ready got %b exp 11000", cmt_ready); end
        tick();
        clear_inputs();
        n_checks++; if (wb_valid !== 1'b1 || wb_uuid !== 44'd50 || perf !== 44'd1) begin n_fail++; $display("FAIL byp_wb got v=%0h uuid=%0d perf=%0d exp 1 50 1", wb_valid, wb_uuid, perf); end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || perf !== 44'd1) begin n_fail++; $display("FAIL byp_after got v=%0h perf=%0d exp 0 1", wb_valid, perf); end
    endtask

    task automatic test_reset_in_lock();
        do_reset();
        set_req(1, 44'd70, 5'd8, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (cmt_ready !== 5'b00000) begin n_fail++; $display("FAIL rl_ready_in_reset got %b exp 00000", cmt_ready); end
        tick();
        reset = 1'b0;
        n_checks++; if (wb_valid !== 1'b0 || perf !== '0) begin n_fail++; $display("FAIL rl_wb got v=%0h perf=%0d exp 0 0", wb_valid, perf); end
        set_req(0, 44'd80, 5'd2, 1'b1, 1'b1);
        set_req(1, 44'd71, 5'd8, 1'b1, 1'b1);
        #1;
        n_checks++; if (cmt_ready !== 5'b00001) begin n_fail++; $display("FAIL rl_tie got %b exp 00001", cmt_ready); end
        tick();
        clear_inputs();
        n_checks++; if (wb_uuid !== 44'd80) begin n_fail++; $display("FAIL rl_tie_wb got %0d exp 80", wb_uuid); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_lock_multibeat();
        test_idle_owner();
        test_bypass();
        test_reset_in_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
